// File: rtl/booth_mul_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// booth_mul_pkg
// Shared types and helpers for the Booth multiplier dispatcher.
//   MUL_DATA_WIDTH / MUL_TAG_WIDTH : operand and tag widths of a request
//   disp_state_e                   : dispatcher FSM states
//   mul_req_s                      : one queued request {a, b, tag}
//   pending_width()                : width of the pending counter for a depth
// ---------------------------------------------------------------------------
package booth_mul_pkg;

    localparam int MUL_DATA_WIDTH = 32;
    localparam int MUL_TAG_WIDTH  = 4;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic [MUL_DATA_WIDTH-1:0] a;
        logic [MUL_DATA_WIDTH-1:0] b;
        logic [MUL_TAG_WIDTH-1:0]  tag;
    } mul_req_s;

    // Pending can reach depth + 2 (full FIFO, one in flight, one held), so
    // the counter must represent depth + 2 inclusive.
    function automatic int pending_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/booth_mul_dispatcher_if.sv
// ---------------------------------------------------------------------------
// booth_mul_dispatcher_if
// Bundles the dispatcher's request stream, multiplier link and result stream.
//   slave  modport : the dispatcher's view
//   master modport : the environment's view (producer, multiplier, consumer)
// Request  : in_valid, in_ready, in_a, in_b, in_tag
// Mult link: mul_a, mul_b, mul_valid_entry, mul_clk_en, mul_rst_n,
//            mul_result, mul_data_valid, mul_busy
// Result   : out_valid, out_ready, out_result, out_tag
// Status   : pending
// ---------------------------------------------------------------------------
interface booth_mul_dispatcher_if
    import booth_mul_pkg::*;
#(
    parameter int DATA_WIDTH = MUL_DATA_WIDTH,
    parameter int TAG_WIDTH  = MUL_TAG_WIDTH,
    parameter int PEND_WIDTH = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_a;
    logic [DATA_WIDTH-1:0]   in_b;
    logic [TAG_WIDTH-1:0]    in_tag;

    logic [DATA_WIDTH-1:0]   mul_a;
    logic [DATA_WIDTH-1:0]   mul_b;
    logic                    mul_valid_entry;
    logic                    mul_clk_en;
    logic                    mul_rst_n;
    logic [2*DATA_WIDTH-1:0] mul_result;
    logic                    mul_data_valid;
    logic                    mul_busy;

    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] out_result;
    logic [TAG_WIDTH-1:0]    out_tag;

    logic [PEND_WIDTH-1:0]   pending;

    modport slave (
        input  in_valid, in_a, in_b, in_tag,
        input  mul_result, mul_data_valid, mul_busy,
        input  out_ready,
        output in_ready,
        output mul_a, mul_b, mul_valid_entry, mul_clk_en, mul_rst_n,
        output out_valid, out_result, out_tag,
        output pending
    );

    modport master (
        output in_valid, in_a, in_b, in_tag,
        output mul_result, mul_data_valid, mul_busy,
        output out_ready,
        input  in_ready,
        input  mul_a, mul_b, mul_valid_entry, mul_clk_en, mul_rst_n,
        input  out_valid, out_result, out_tag,
        input  pending
    );

endinterface

// File: rtl/booth_mul_dispatcher_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head word.
//   clk_i, rst_i : clock, synchronous active-high reset (clears pointers)
//   push_i       : write data_i (ignored while full)
//   pop_i        : drop the head (ignored while empty)
//   head_o       : current head entry, valid while empty_o = 0
//   full_o/empty_o/count_o : occupancy
// Pointers carry one extra wrap bit to tell full from empty.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = head_q;

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // The head is prefetched from the post-pop read pointer. When that slot
    // is the one being written this cycle the RAM does not hold it yet, so
    // the incoming word is forwarded.
    always_ff @(posedge clk_i) begin
        head_q <= (wr_ptr_q == rd_ptr_d) ? data_i : mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/booth_mul_dispatcher.sv
// ---------------------------------------------------------------------------
// booth_mul_dispatcher
// Front-end for a sequential signed Booth multiplier. Tagged operand pairs
// are queued in a FIFO, issued one at a time while the multiplier is idle,
// and the 2*DATA_WIDTH product is returned with its tag through a registered
// valid/ready slot. The multiplier is frozen while that slot is stalled.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request stream, multiplier link, result stream, pending
// ---------------------------------------------------------------------------
module booth_mul_dispatcher
    import booth_mul_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    booth_mul_dispatcher_if.slave bus
);
    localparam int REQ_WIDTH  = $bits(mul_req_s);
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;
    localparam int PEND_WIDTH = pending_width(FIFO_DEPTH);

    mul_req_s                  in_req, head_req;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_WIDTH-1:0]      fifo_count;

    disp_state_e               state_q, state_d;
    logic                      seen_busy_q, seen_busy_d;
    logic [MUL_TAG_WIDTH-1:0]  inflight_tag_q, inflight_tag_d;
    logic                      out_valid_q;
    logic [2*MUL_DATA_WIDTH-1:0] out_result_q;
    logic [MUL_TAG_WIDTH-1:0]  out_tag_q;

    logic                      clk_en, issue, capture;

    assign in_req    = '{a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
    assign fifo_push = bus.in_valid & ~fifo_full;

    sync_fifo #(
        .WIDTH (REQ_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (in_req),
        .pop_i   (fifo_pop),
        .head_o  (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Everything downstream of the FIFO advances only while the result slot
    // can take a new product (empty, or being drained this cycle).
    assign clk_en = ~(out_valid_q & ~bus.out_ready);

    always_comb begin
        state_d        = state_q;
        seen_busy_d    = seen_busy_q;
        inflight_tag_d = inflight_tag_q;
        issue          = 1'b0;
        capture        = 1'b0;
        fifo_pop       = 1'b0;
        case (state_q)
            ISSUE: begin
                issue = ~fifo_empty & ~bus.mul_busy;
                if (issue && clk_en) begin
                    fifo_pop       = 1'b1;
                    inflight_tag_d = head_req.tag;
                    seen_busy_d    = 1'b0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                // data_valid can still be high from the previous product
                // before the multiplier starts, so require a busy phase first.
                if (bus.mul_busy) begin
                    seen_busy_d = 1'b1;
                end
                capture = seen_busy_q & ~bus.mul_busy & bus.mul_data_valid & clk_en;
                if (capture) begin
                    if (!fifo_empty) begin
                        // Back-to-back: start the next operand the same cycle.
                        issue          = 1'b1;
                        fifo_pop       = 1'b1;
                        inflight_tag_d = head_req.tag;
                        seen_busy_d    = 1'b0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ISSUE;
            seen_busy_q    <= 1'b0;
            inflight_tag_q <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_tag_q      <= '0;
        end else begin
            state_q        <= state_d;
            seen_busy_q    <= seen_busy_d;
            inflight_tag_q <= inflight_tag_d;
            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= bus.mul_result;
                out_tag_q    <= inflight_tag_q;
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready        = ~fifo_full;
    assign bus.mul_a           = head_req.a;
    assign bus.mul_b           = head_req.b;
    assign bus.mul_valid_entry = issue;
    assign bus.mul_clk_en      = clk_en;
    assign bus.mul_rst_n       = ~rst_i;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_result      = out_result_q;
    assign bus.out_tag         = out_tag_q;
    assign bus.pending         = PEND_WIDTH'(fifo_count)
                               + PEND_WIDTH'(state_q == WAIT)
                               + PEND_WIDTH'(out_valid_q);

endmodule
